// File: rtl/imem_loader_bank.sv
// Instruction memory with a streamed program-load port and a pipelined fetch port. Optional per-word parity: IMEM_PARITY_EN.
// Latency: a fetch accepted in RUN is answered on the next cycle; load writes take effect at the edge.
// Backpressure: fetch_stall freezes the response registers and blocks acceptance; the load port is never throttled.
module imem_loader_bank #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 256,
    parameter int              ADDR_W    = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h00000013)
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       load_start,
    input  logic                       load_we,
    input  logic [XLEN-1:0]            load_wdata,
    input  logic                       load_end,
    output logic [$clog2(DEPTH+1)-1:0] load_count,
    output logic                       load_ovf,
`ifdef IMEM_PARITY_EN
    input  logic                       par_flip,
    output logic                       parity_err,
`endif
    input  logic                       fetch_req,
    input  logic [ADDR_W-1:0]          fetch_addr,
    input  logic                       fetch_stall,
    output logic                       fetch_valid,
    output logic [XLEN-1:0]            fetch_instr,
    output logic [1:0]                 fetch_fault,
    output logic                       busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW    = ADDR_W - 2;
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = XLEN + 1;
`else
    localparam int MEM_W = XLEN;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   in_load, in_run;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // load_start outranks load_end in every state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (load_start) state_d = ST_LOAD;
            ST_LOAD: begin
                if (load_start) begin
                    state_d = ST_LOAD;
                end else if (load_end) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  if (load_start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_load = (state_q == ST_LOAD);
        in_run  = (state_q == ST_RUN);
        busy    = (state_q != ST_RUN);
    end

    logic [CNT_W-1:0] ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             wr_en;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] mem [DEPTH];

    always_comb begin
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        wr_en = 1'b0;
        if (load_start) begin
            ptr_d = '0;
            ovf_d = 1'b0;
        end else if (in_load && load_we) begin
            if (ptr_q == CNT_W'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                ptr_d = ptr_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef IMEM_PARITY_EN
    // Even parity over the data word; par_flip corrupts it to exercise the checker.
    assign wr_word = {(^load_wdata) ^ par_flip, load_wdata};
`else
    assign wr_word = load_wdata;
`endif

    // Array contents survive reset so a program outlives a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q[IDX_W-1:0]] <= wr_word;
        end
    end

    logic [IW-1:0]    f_idx;
    logic             f_misal, f_oor, f_par_bad;
    logic [MEM_W-1:0] rd_word;

    assign f_idx   = fetch_addr[ADDR_W-1:2];
    assign f_misal = |fetch_addr[1:0];
    assign f_oor   = (f_idx >= IW'(DEPTH));
    assign rd_word = mem[f_idx[IDX_W-1:0]];
`ifdef IMEM_PARITY_EN
    assign f_par_bad = rd_word[XLEN] != (^rd_word[XLEN-1:0]);
`else
    assign f_par_bad = 1'b0;
`endif

    logic            vld_q, vld_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [1:0]      fault_q, fault_d;
    logic            perr_q, perr_d;

    always_comb begin
        vld_d   = vld_q;
        instr_d = instr_q;
        fault_d = fault_q;
        perr_d  = perr_q;
        if (fetch_stall) begin
            vld_d = vld_q;
        end else if (!in_run) begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
            fault_d = 2'b00;
            perr_d  = 1'b0;
        end else if (fetch_req) begin
            vld_d  = 1'b1;
            perr_d = 1'b0;
            if (f_misal) begin
                instr_d = NOP_INSTR;
                fault_d = 2'b01;
            end else if (f_oor) begin
                instr_d = NOP_INSTR;
                fault_d = 2'b10;
            end else if (f_par_bad) begin
                instr_d = NOP_INSTR;
                fault_d = 2'b00;
                perr_d  = 1'b1;
            end else begin
                instr_d = rd_word[XLEN-1:0];
                fault_d = 2'b00;
            end
        end else begin
            // Idle cycle in RUN: drop valid, keep the last word and fault visible.
            vld_d  = 1'b0;
            perr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_q   <= 1'b0;
            instr_q <= NOP_INSTR;
            fault_q <= 2'b00;
            perr_q  <= 1'b0;
        end else begin
            vld_q   <= vld_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            perr_q  <= perr_d;
        end
    end

    assign load_count  = ptr_q;
    assign load_ovf    = ovf_q;
    assign fetch_valid = vld_q;
    assign fetch_instr = instr_q;
    assign fetch_fault = fault_q;
`ifdef IMEM_PARITY_EN
    assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_imem_loader_bank.sv
// Self-checking bench for imem_loader_bank with a word-array reference model.
module tb_imem_loader_bank;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk;
    logic        nrst;
    logic        load_start, load_we, load_end;
    logic [31:0] load_wdata;
    logic [8:0]  load_count;
    logic        load_ovf;
    logic        fetch_req, fetch_stall;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [1:0]  fetch_fault;
    logic        busy;
`ifdef IMEM_PARITY_EN
    logic        par_flip;
    logic        parity_err;
`endif

    imem_loader_bank dut (
        .clk         (clk),
        .nrst        (nrst),
        .load_start  (load_start),
        .load_we     (load_we),
        .load_wdata  (load_wdata),
        .load_end    (load_end),
        .load_count  (load_count),
        .load_ovf    (load_ovf),
`ifdef IMEM_PARITY_EN
        .par_flip    (par_flip),
        .parity_err  (parity_err),
`endif
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_fault (fetch_fault),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdl_mem [DEPTH];
    int          mdl_count;
    bit          mdl_ovf;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] ins, output logic [1:0] f);
        if (a % 4 != 0) begin
            ins = NOP; f = 2'b01;
        end else if (a / 4 >= DEPTH) begin
            ins = NOP; f = 2'b10;
        end else begin
            ins = mdl_mem[a / 4]; f = 2'b00;
        end
    endfunction

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        mdl_count = 0;
        mdl_ovf = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] w);
        load_we = 1'b1;
        load_wdata = w;
        tick();
        load_we = 1'b0;
        if (mdl_count < DEPTH) begin
            mdl_mem[mdl_count] = w;
            mdl_count++;
        end else begin
            mdl_ovf = 1'b1;
        end
    endtask

    task automatic end_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic issue_fetch(input logic [31:0] a);
        fetch_req = 1'b1;
        fetch_addr = a;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %0b want 1", busy); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", fetch_valid); end
        n_cmp++; if (fetch_instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", fetch_instr, NOP); end
        n_cmp++; if (fetch_fault !== 2'b00) begin n_err++; $display("FAIL reset_fault: got %b want 00", fetch_fault); end
        n_cmp++; if (load_count !== 9'd0 || load_ovf !== 1'b0) begin n_err++; $display("FAIL reset_load: got count %0d ovf %0b want 0 0", load_count, load_ovf); end
        nrst = 1'b1;
        issue_fetch(32'h0);
        n_cmp++; if (fetch_valid !== 1'b0 || fetch_instr !== NOP || busy !== 1'b1) begin
            n_err++; $display("FAIL idle_fetch: got v%0b %h busy%0b want v0 %h busy1", fetch_valid, fetch_instr, busy, NOP);
        end
    endtask

    task automatic test_basic_load();
        start_load();
        write_word(32'h11111111);
        write_word(32'h22222222);
        write_word(32'h33333333);
        write_word(32'h44444444);
        end_load();
        n_cmp++; if (load_count !== 9'd4) begin n_err++; $display("FAIL basic_count: got %0d want 4", load_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %0b want 0", busy); end
        issue_fetch(32'h8);
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h33333333 || fetch_fault !== 2'b00) begin
            n_err++; $display("FAIL basic_fetch: got v%0b %h f%b want v1 33333333 f00", fetch_valid, fetch_instr, fetch_fault);
        end
        tick();
        n_cmp++; if (fetch_valid !== 1'b0 || fetch_instr !== 32'h33333333) begin
            n_err++; $display("FAIL basic_hold: got v%0b %h want v0 33333333", fetch_valid, fetch_instr);
        end
    endtask

    task automatic test_faults();
        issue_fetch(32'h6);
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== NOP || fetch_fault !== 2'b01) begin
            n_err++; $display("FAIL misaligned: got v%0b %h f%b want v1 %h f01", fetch_valid, fetch_instr, fetch_fault, NOP);
        end
        issue_fetch(32'(4 * DEPTH));
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== NOP || fetch_fault !== 2'b10) begin
            n_err++; $display("FAIL out_of_range: got v%0b %h f%b want v1 %h f10", fetch_valid, fetch_instr, fetch_fault, NOP);
        end
        issue_fetch(32'(4 * DEPTH + 1));
        n_cmp++; if (fetch_fault !== 2'b01) begin n_err++; $display("FAIL fault_priority: got %b want 01", fetch_fault); end
    endtask

    task automatic test_back_to_back();
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        tick();
        fetch_addr = 32'h4;
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h11111111) begin
                n_err++; $display("FAIL stall_hold%0d: got v%0b %h want v1 11111111", i, fetch_valid, fetch_instr);
            end
        end
        fetch_stall = 1'b0;
        tick();
        fetch_req = 1'b0;
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== 32'h22222222) begin
            n_err++; $display("FAIL after_stall: got v%0b %h want v1 22222222", fetch_valid, fetch_instr);
        end
        tick();
        n_cmp++; if (fetch_valid !== 1'b0) begin n_err++; $display("FAIL after_stall_drop: got %0b want 0", fetch_valid); end
    endtask

    task automatic test_random_fetch();
        localparam int NLOAD = 40;
        logic        exp_v;
        logic [31:0] exp_i, a;
        logic [1:0]  exp_f;
        start_load();
        for (int i = 0; i < NLOAD; i++) write_word($urandom);
        end_load();
        issue_fetch(32'h0);
        exp_v = 1'b1; exp_i = mdl_mem[0]; exp_f = 2'b00;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0, 1: a = 32'($urandom_range(0, NLOAD - 1)) * 4;
                2:    a = 32'($urandom_range(0, NLOAD - 1)) * 4 + 32'($urandom_range(1, 3));
                default: a = 32'($urandom_range(DEPTH, 32'h3FFFFFFF)) * 4;
            endcase
            fetch_addr = a;
            fetch_req = ($urandom_range(0, 9) < 7);
            fetch_stall = ($urandom_range(0, 3) == 0);
            if (!fetch_stall) begin
                if (fetch_req) begin
                    exp_v = 1'b1;
                    ref_fetch(a, exp_i, exp_f);
                end else begin
                    exp_v = 1'b0;
                end
            end
            tick();
            n_cmp++; if (fetch_valid !== exp_v || fetch_instr !== exp_i || fetch_fault !== exp_f) begin
                n_err++; $display("FAIL rand%0d addr %h: got v%0b %h f%b want v%0b %h f%b", n, a,
                                  fetch_valid, fetch_instr, fetch_fault, exp_v, exp_i, exp_f);
            end
        end
        fetch_req = 1'b0;
        fetch_stall = 1'b0;
        tick();
    endtask

    task automatic test_load_controls();
        logic [31:0] w1, w2;
        w1 = $urandom;
        w2 = $urandom;
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        mdl_count = 0;
        mdl_ovf = 1'b0;
        n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== mdl_mem[0] || busy !== 1'b1 || load_count !== 9'd0) begin
            n_err++; $display("FAIL pending_resp: got v%0b %h busy%0b cnt%0d want v1 %h busy1 cnt0",
                              fetch_valid, fetch_instr, busy, load_count, mdl_mem[0]);
        end
        tick();
        fetch_req = 1'b0;
        n_cmp++; if (fetch_valid !== 1'b0 || fetch_instr !== NOP || fetch_fault !== 2'b00) begin
            n_err++; $display("FAIL load_fetch: got v%0b %h f%b want v0 %h f00", fetch_valid, fetch_instr, fetch_fault, NOP);
        end
        write_word(w1);
        load_start = 1'b1;
        load_end = 1'b1;
        tick();
        load_start = 1'b0;
        load_end = 1'b0;
        mdl_count = 0;
        n_cmp++; if (busy !== 1'b1 || load_count !== 9'd0) begin
            n_err++; $display("FAIL start_wins: got busy%0b cnt%0d want busy1 cnt0", busy, load_count);
        end
        load_we = 1'b1;
        load_end = 1'b1;
        load_wdata = w2;
        tick();
        load_we = 1'b0;
        load_end = 1'b0;
        mdl_mem[0] = w2;
        mdl_count = 1;
        n_cmp++; if (busy !== 1'b0 || load_count !== 9'd1) begin
            n_err++; $display("FAIL we_with_end: got busy%0b cnt%0d want busy0 cnt1", busy, load_count);
        end
        write_word(~w2);
        mdl_mem[1] = mdl_mem[1];
        mdl_count = 1;
        mdl_mem[0] = w2;
        n_cmp++; if (load_count !== 9'd1) begin n_err++; $display("FAIL run_we_count: got %0d want 1", load_count); end
        issue_fetch(32'h0);
        n_cmp++; if (fetch_instr !== w2) begin n_err++; $display("FAIL run_we_ignored: got %h want %h", fetch_instr, w2); end
    endtask

    task automatic test_overflow();
        logic [31:0] e_i;
        logic [1:0]  e_f;
        start_load();
        for (int i = 0; i < DEPTH; i++) write_word($urandom);
        n_cmp++; if (load_count !== 9'(DEPTH) || load_ovf !== 1'b0) begin
            n_err++; $display("FAIL full_no_ovf: got cnt%0d ovf%0b want cnt%0d ovf0", load_count, load_ovf, DEPTH);
        end
        write_word($urandom);
        n_cmp++; if (load_count !== 9'(DEPTH) || load_ovf !== 1'b1 || load_ovf !== mdl_ovf) begin
            n_err++; $display("FAIL overflow: got cnt%0d ovf%0b want cnt%0d ovf1", load_count, load_ovf, DEPTH);
        end
        start_load();
        n_cmp++; if (load_count !== 9'd0 || load_ovf !== 1'b0) begin
            n_err++; $display("FAIL ovf_clear: got cnt%0d ovf%0b want 0 0", load_count, load_ovf);
        end
        end_load();
        issue_fetch(32'(4 * (DEPTH - 1)));
        ref_fetch(32'(4 * (DEPTH - 1)), e_i, e_f);
        n_cmp++; if (fetch_instr !== e_i || fetch_fault !== e_f) begin
            n_err++; $display("FAIL last_word: got %h f%b want %h f%b", fetch_instr, fetch_fault, e_i, e_f);
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] e_i;
        logic [1:0]  e_f;
        start_load();
        write_word($urandom);
        write_word($urandom);
        nrst = 1'b0;
        #2;
        mdl_count = 0;
        n_cmp++; if (busy !== 1'b1 || load_count !== 9'd0 || fetch_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset: got busy%0b cnt%0d v%0b want busy1 cnt0 v0", busy, load_count, fetch_valid);
        end
        tick();
        nrst = 1'b1;
        start_load();
        end_load();
        for (int k = 0; k < 4; k++) begin
            issue_fetch(32'(4 * k));
            ref_fetch(32'(4 * k), e_i, e_f);
            n_cmp++; if (fetch_valid !== 1'b1 || fetch_instr !== e_i) begin
                n_err++; $display("FAIL retain%0d: got v%0b %h want v1 %h", k, fetch_valid, fetch_instr, e_i);
            end
        end
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        logic [31:0] w;
        w = $urandom;
        start_load();
        write_word(w);
        par_flip = 1'b1;
        write_word(~w);
        par_flip = 1'b0;
        end_load();
        issue_fetch(32'h0);
        n_cmp++; if (parity_err !== 1'b0 || fetch_instr !== w) begin
            n_err++; $display("FAIL parity_good: got perr%0b %h want perr0 %h", parity_err, fetch_instr, w);
        end
        issue_fetch(32'h4);
        n_cmp++; if (parity_err !== 1'b1 || fetch_instr !== NOP || fetch_valid !== 1'b1) begin
            n_err++; $display("FAIL parity_bad: got perr%0b %h v%0b want perr1 %h v1", parity_err, fetch_instr, fetch_valid, NOP);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        load_start = 1'b0;
        load_we = 1'b0;
        load_end = 1'b0;
        load_wdata = '0;
        fetch_req = 1'b0;
        fetch_stall = 1'b0;
        fetch_addr = '0;
`ifdef IMEM_PARITY_EN
        par_flip = 1'b0;
`endif
        mdl_count = 0;
        mdl_ovf = 1'b0;
        test_reset();
        test_basic_load();
        test_faults();
        test_back_to_back();
        test_random_fetch();
        test_load_controls();
        test_overflow();
        test_reset_mid_load();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader_bank.md
Name: imem_loader_bank

Overview:
- Parametrised instruction memory with a single clock domain, a pipelined fetch port and a streaming program-load port.
- Replaces the fixed 100-word ROM and its separate debug clock.
- Sits between the debug/boot module, which streams a program in, and the core's fetch stage, which reads one instruction per cycle with a 1-cycle latency.
- Adds a load/run state machine, byte-to-word address translation, fault flags and stall holding.

Parameters:
XLEN, 32, instruction/data width in bits
DEPTH, 256, number of words (need not be a power of two)
ADDR_W, 32, width of fetch byte address
NOP_INSTR, 32'h00000013, word driven when no valid instruction is presented

Ports:
clk  input  1  system clock; all logic is on posedge
nrst  input  1  asynchronous active-low reset
load_start  input  1  pulse: enter LOAD, clear load pointer
load_we  input  1  write load_wdata at load pointer
load_wdata  input  XLEN  instruction word to store
load_end  input  1  pulse: leave LOAD, enter RUN
load_count  output  $clog2(DEPTH+1)  words written in current load
load_ovf  output  1  sticky: write attempted with pointer at DEPTH
fetch_req  input  1  fetch request this cycle
fetch_addr  input  ADDR_W  byte address of fetch
fetch_stall  input  1  hold current response, accept no request
fetch_valid  output  1  fetch_instr valid (1 cycle after accepted req)
fetch_instr  output  XLEN  fetched word
fetch_fault  output  2  bit0 misaligned, bit1 out of range
busy  output  1  high when state is not RUN

Behaviour:
- Reset (nrst low, async): state=IDLE, load pointer=0, load_count=0, load_ovf=0, fetch_valid=0, fetch_instr=NOP_INSTR, fetch_fault=0, busy=1. Memory array is not cleared.
- States:
  - IDLE: load_start -> LOAD. Otherwise stay. Fetches are ignored.
  - LOAD: load_we writes mem[ptr]=load_wdata, then ptr++ and load_count++.
    - If ptr==DEPTH, the write is dropped and load_ovf is set.
    - load_end -> RUN. load_end together with load_we in the same cycle performs the write first, then transitions.
    - load_start in LOAD restarts: ptr=0, count=0, load_ovf cleared.
  - RUN: load_start -> LOAD, clearing ptr, count and load_ovf. load_we is ignored in RUN and IDLE.
- Fetch in RUN:
  - A request is accepted when fetch_req=1 and fetch_stall=0. The word index is fetch_addr[ADDR_W-1:2].
  - Next cycle: fetch_valid=1.
    - If fetch_addr[1:0]!=0: fault bit0 set, instr=NOP_INSTR.
    - Else if index>=DEPTH: fault bit1 set, instr=NOP_INSTR.
    - Else: instr=mem[index], fault=0.
  - No accepted request: next cycle fetch_valid=0, fetch_instr and fetch_fault hold their last values.
- Stall: while fetch_stall=1, fetch_valid/instr/fault hold exactly. A pending fetch_req is not accepted.
- Fetch in IDLE/LOAD: fetch_valid=0 next cycle, instr=NOP_INSTR, fault=0.
- LOAD entered with a response pending: that response is still presented once, then fetch_valid drops.
- Read-during-write does not occur, since load and fetch are mutually exclusive by state.
- load_start and load_end asserted together: load_start wins.
- Memory contents are retained across RUN->LOAD->RUN except for words rewritten.

Optional Feature:
- Macro IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed at write time.
  - On a fetch, the parity is rechecked. A mismatch sets output port parity_err (1 bit, reset 0) for the cycle fetch_valid=1 and replaces fetch_instr with NOP_INSTR.
  - parity_err is held under stall like the other fetch outputs.
  - A test-only input par_flip (1 bit) inverts the stored parity bit on the load write it accompanies.
- Not defined: no parity storage, and ports parity_err/par_flip are absent.

Test Plan:
- Reset, then fetch_req at addr 0 -> fetch_valid=0, fetch_instr=32'h00000013, busy=1.
- Load 4 words (0x11111111, 0x22222222, 0x33333333, 0x44444444), load_end, fetch byte addr 0x8 -> next cycle fetch_valid=1, fetch_instr=0x33333333, fault=0, load_count=4, busy=0.
- Fetch addr 0x6 -> fault=2'b01, instr=NOP. Fetch addr 4*DEPTH (0x400) -> fault=2'b10, instr=NOP.
- Back-to-back fetches at 0x0 and 0x4 with fetch_stall high for 3 cycles after the first -> 0x11111111 held 3 cycles. The 0x4 request is accepted only after the stall, giving 0x22222222 the cycle after.
- Write DEPTH+1 words in LOAD -> load_count=DEPTH, load_ovf=1. A new load_start clears load_ovf and load_count.
- Assert nrst mid-LOAD after 2 writes -> state IDLE immediately, load_count=0. Words previously loaded persist after a reload without overwriting them.
